io_uart_tx: RTL and testbench

IO_UART_TX -- requirements
Module: io_uart_tx

---
 rtl/io_pkg.sv | 30 +++
 rtl/io_fifo4.sv | 51 +++++
 rtl/io_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_io_uart_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared IO register map, STATUS bit positions, FIFO sizing and UART TX states
package io_pkg;

    localparam logic [15:0] REG_TXDATA = 16'd0;
    localparam logic [15:0] REG_STATUS = 16'd1;
    localparam logic [15:0] REG_CTRL   = 16'd2;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_EN    = 4;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/io_fifo4.sv
// rtl/io_fifo4.sv - 4-entry byte FIFO; a push into a full FIFO is accepted only alongside a pop
module io_fifo4
    import io_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [7:0]            i_data,
    output logic [7:0]            o_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [FIFO_CNT_W-1:0] o_count
);

    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Pointers wrap naturally at FIFO_PTR_W bits.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - IO-mapped UART transmitter with 4-byte FIFO; UART_TX_PARITY_EN adds an even parity bit
module io_uart_tx
    import io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter logic [15:0] CLKS_PER_BIT = 16'd868
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_address,
    input  logic [15:0] io_write_value,
    input  logic        io_write_en,
    input  logic        io_read_en,
    output logic [15:0] io_read_value,
    output logic        tx,
    output logic        tx_busy
);

    localparam logic [15:0] ADDR_TXDATA = BASE_ADDR + REG_TXDATA;
    localparam logic [15:0] ADDR_STATUS = BASE_ADDR + REG_STATUS;
    localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + REG_CTRL;
    localparam logic [15:0] BAUD_RELOAD = CLKS_PER_BIT - 16'd1;

    uart_state_e           r_state;
    logic [15:0]           r_baud_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_enable;
    logic                  r_overflow;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic                  w_wr_txdata;
    logic                  w_wr_status;
    logic                  w_wr_ctrl;
    logic                  w_baud_done;
    logic                  w_pop;
    logic                  w_ovf_event;
    logic [7:0]            w_fifo_data;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [FIFO_CNT_W-1:0] w_fifo_count;
    logic [15:0]           w_status;
    logic                  w_unused_wdata;

    assign w_wr_txdata    = io_write_en && (io_address == ADDR_TXDATA);
    assign w_wr_status    = io_write_en && (io_address == ADDR_STATUS);
    assign w_wr_ctrl      = io_write_en && (io_address == ADDR_CTRL);
    assign w_baud_done    = (r_baud_cnt == 16'd0);
    assign w_unused_wdata = ^io_write_value[15:8];

    // A new frame starts from IDLE, or straight out of the last STOP cycle so frames abut.
    assign w_pop = r_enable && !w_fifo_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));
    assign w_ovf_event = w_wr_txdata && (w_fifo_count == FIFO_CNT_W'(FIFO_DEPTH)) && !w_pop;

    io_fifo4 u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_wr_txdata),
        .i_pop   (w_pop),
        .i_data  (io_write_value[7:0]),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (w_pop) begin
            r_state    <= ST_START;
            r_baud_cnt <= BAUD_RELOAD;
            r_bit_idx  <= 3'd0;
            r_shift    <= w_fifo_data;
`ifdef UART_TX_PARITY_EN
            r_parity   <= even_parity(w_fifo_data);
`endif
        end else if (r_state != ST_IDLE) begin
            if (!w_baud_done) begin
                r_baud_cnt <= r_baud_cnt - 16'd1;
            end else begin
                r_baud_cnt <= BAUD_RELOAD;
                case (r_state)
                    ST_START: r_state <= ST_DATA;
                    ST_DATA: begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                    ST_PARITY: r_state <= ST_STOP;
                    ST_STOP: begin
                        r_state    <= ST_IDLE;
                        r_baud_cnt <= 16'd0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // A same-cycle overflow event outranks the W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable   <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_enable <= io_write_value[0];
            if (w_ovf_event)
                r_overflow <= 1'b1;
            else if (w_wr_status && io_write_value[STAT_OVF])
                r_overflow <= 1'b0;
        end
    end

    assign tx_busy = (r_state != ST_IDLE);

    always_comb begin
        tx = 1'b1;
        case (r_state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = r_parity;
`endif
            default:   tx = 1'b1;
        endcase
    end

    always_comb begin
        w_status             = 16'h0000;
        w_status[STAT_EMPTY] = w_fifo_empty;
        w_status[STAT_FULL]  = w_fifo_full;
        w_status[STAT_BUSY]  = tx_busy;
        w_status[STAT_OVF]   = r_overflow;
        w_status[STAT_EN]    = r_enable;
    end

    always_comb begin
        io_read_value = 16'h0000;
        if (io_read_en) begin
            if (io_address == ADDR_STATUS)
                io_read_value = w_status;
            else if (io_address == ADDR_CTRL)
                io_read_value = {15'b0, r_enable};
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - self-checking bench for io_uart_tx (frame length follows UART_TX_PARITY_EN)
module tb_io_uart_tx;

    localparam logic [15:0] CPB       = 16'd4;
    localparam logic [15:0] BASE      = 16'hFF00;
    localparam logic [15:0] A_TXDATA  = BASE;
    localparam logic [15:0] A_STATUS  = BASE + 16'd1;
    localparam logic [15:0] A_CTRL    = BASE + 16'd2;
    localparam int          BIT_CYC   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] io_address = 16'h0;
    logic [15:0] io_write_value = 16'h0;
    logic        io_write_en = 1'b0;
    logic        io_read_en = 1'b0;
    logic [15:0] io_read_value;
    logic        tx;
    logic        tx_busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_cnt = 0;

    byte unsigned model_q[$];
    logic         m_en = 1'b1;
    logic         m_ovf = 1'b0;
    logic         obs_bits [8][11];

    typedef struct {
        logic [15:0] addr;
        logic        re;
        logic [15:0] exp;
    } rd_vec_t;

    io_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .io_address     (io_address),
        .io_write_value (io_write_value),
        .io_write_en    (io_write_en),
        .io_read_en     (io_read_en),
        .io_read_value  (io_read_value),
        .tx             (tx),
        .tx_busy        (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        io_address     = a;
        io_write_value = v;
        io_write_en    = 1'b1;
        @(posedge clk); #1;
        io_write_en    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        io_address = a;
        io_read_en = 1'b1;
        #1;
        v = io_read_value;
        io_read_en = 1'b0;
    endtask

    // Line level for bit slot k of a frame carrying d.
    function automatic logic model_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (FRAME_BITS == 11 && k == 9) return ^d;
        return 1'b1;
    endfunction

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s = 16'h0000;
        s[4] = m_en;
        s[3] = m_ovf;
        s[1] = (model_q.size() == 4);
        s[0] = (model_q.size() == 0);
        return s;
    endfunction

    task automatic model_push(input byte unsigned b);
        if (model_q.size() < 4) model_q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic push_byte(input byte unsigned b);
        wr(A_TXDATA, {8'h00, b});
        model_push(b);
    endtask

    // Entered one step after the edge that made a frame startable.
    task automatic expect_stream(input string name, input int n);
        int          errs;
        int          busy_cyc;
        logic [15:0] st;
        logic [7:0]  d;
        errs = 0;
        busy_cyc = 0;
        check({name, "_idle_before_start"}, {30'b0, tx_busy, tx}, 32'h1);
        for (int j = 0; j < n; j++) begin
            d = model_q.pop_front();
            for (int c = 0; c < FRAME_BITS * BIT_CYC; c++) begin
                @(posedge clk); #1;
                rd(A_STATUS, st);
                if (tx !== model_bit(d, c / BIT_CYC)) errs++;
                if (tx_busy === 1'b1) busy_cyc++;
                if (st[0] !== (model_q.size() == 0)) errs++;
                if (c % BIT_CYC == 1) obs_bits[j][c / BIT_CYC] = tx;
            end
        end
        @(posedge clk); #1;
        check({name, "_idle_after"}, {30'b0, tx_busy, tx}, 32'h1);
        check({name, "_bit_errors"}, errs, 0);
        check({name, "_busy_cycles"}, busy_cyc, n * FRAME_BITS * BIT_CYC);
    endtask

    initial begin
        rd_vec_t     vecs[6];
        logic [15:0] st;
        logic [9:0]  a5_got;
        logic [9:0]  a5_exp;
        int          n_push;
        int          t0;
        logic        dropped;
        logic        stayed_idle;

        vecs[0] = '{16'hFF01, 1'b1, 16'h0011};
        vecs[1] = '{16'hFF02, 1'b1, 16'h0001};
        vecs[2] = '{16'hFF00, 1'b1, 16'h0000};
        vecs[3] = '{16'hFF03, 1'b1, 16'h0000};
        vecs[4] = '{16'hFF01, 1'b0, 16'h0000};
        vecs[5] = '{16'h0001, 1'b1, 16'h0000};

        repeat (3) @(posedge clk); #1;
        check("tx_high_in_reset", {30'b0, tx_busy, tx}, 32'h1);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            io_address = vecs[i].addr;
            io_read_en = vecs[i].re;
            #1;
            check($sformatf("rdvec%0d", i), io_read_value, vecs[i].exp);
            io_read_en = 1'b0;
        end
        check("tx_idle_after_reset", tx, 1);

        // Single A5 frame, also compared against the literal bit pattern.
        push_byte(8'hA5);
        expect_stream("frame_a5", 1);
        a5_exp = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 9; k++) a5_got[k] = obs_bits[0][k];
        a5_got[9] = obs_bits[0][FRAME_BITS-1];
        check("frame_a5_pattern", a5_got, a5_exp);

        // Overflow: five writes with transmission held off.
        wr(A_CTRL, 16'h0000); m_en = 1'b0;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        rd(A_STATUS, st);
        check("ovf_status_literal", st, 16'h000A);
        check("ovf_status_model", st, model_status());
        wr(A_STATUS, 16'h0008); m_ovf = 1'b0;
        rd(A_STATUS, st);
        check("ovf_cleared", st, 16'h0002);
        wr(A_CTRL, 16'h0001); m_en = 1'b1;
        expect_stream("ovf_four_frames", 4);

        // Three queued bytes go out back to back.
        wr(A_CTRL, 16'h0000); m_en = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        wr(A_CTRL, 16'h0001); m_en = 1'b1;
        expect_stream("b2b_three", 3);

        for (int it = 0; it < 4; it++) begin
            wr(A_CTRL, 16'h0000); m_en = 1'b0;
            n_push = $urandom_range(1, 6);
            for (int i = 0; i < n_push; i++) push_byte(8'($urandom));
            wr(A_STATUS, 16'($urandom) & 16'hFFF7);
            rd(A_STATUS, st);
            check($sformatf("rand%0d_status", it), st, model_status());
            wr(A_STATUS, 16'h0008); m_ovf = 1'b0;
            rd(A_STATUS, st);
            check($sformatf("rand%0d_status_w1c", it), st, model_status());
            wr(A_CTRL, 16'h0001); m_en = 1'b1;
            expect_stream($sformatf("rand%0d", it), model_q.size());
        end

`ifdef UART_TX_PARITY_EN
        wr(A_CTRL, 16'h0000); m_en = 1'b0;
        push_byte(8'h07);
        push_byte(8'h03);
        wr(A_CTRL, 16'h0001); m_en = 1'b1;
        expect_stream("parity", 2);
        check("parity_07", obs_bits[0][9], 1);
        check("parity_03", obs_bits[1][9], 0);
`endif

        // Clearing enable mid-frame lets the frame finish and holds the rest.
        wr(A_CTRL, 16'h0000); m_en = 1'b0;
        push_byte(8'hAA);
        push_byte(8'h55);
        wr(A_CTRL, 16'h0001); m_en = 1'b1;
        t0 = cyc_cnt;
        repeat (10) @(posedge clk); #1;
        wr(A_CTRL, 16'h0000); m_en = 1'b0;
        dropped = 1'b0;
        for (int i = 0; i < 200 && !dropped; i++) begin
            @(posedge clk); #1;
            if (!tx_busy) dropped = 1'b1;
        end
        check("en_clear_frame_completes", dropped, 1);
        check("en_clear_frame_length", cyc_cnt - t0, FRAME_BITS * BIT_CYC + 1);
        void'(model_q.pop_front());
        rd(A_STATUS, st);
        check("en_clear_status", st, model_status());
        stayed_idle = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (tx_busy !== 1'b0 || tx !== 1'b1) stayed_idle = 1'b0;
        end
        check("en_clear_no_new_pop", stayed_idle, 1);

        // Reset in the middle of DATA with a byte still queued behind.
        push_byte(8'h0F);
        wr(A_CTRL, 16'h0001); m_en = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("pre_reset_mid_data", tx, model_bit(8'h55, 2));
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_line", {30'b0, tx_busy, tx}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        model_q.delete();
        m_en = 1'b1;
        m_ovf = 1'b0;
        rd(A_STATUS, st);
        check("status_after_midframe_reset", st, 16'h0011);
        stayed_idle = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (tx_busy !== 1'b0 || tx !== 1'b1) stayed_idle = 1'b0;
        end
        check("fifo_discarded_on_reset", stayed_idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
